shared_reg_arbiter: RTL
=======================

# shared_reg_arbiter

Round-robin write arbiter that shares one synchronous-reset storage register among `N_REQ` requesters. Each requester presents data with a level request, and the block grants one requester per cycle. On a grant it loads that requester's data into the shared register and returns a one-cycle grant pulse as the write acknowledge. It sits between the requesting pipelines and the shared flop bank, and is the only writer of that register.

## Interface
Parameters:
- `N_REQ`, default 4: number of requesters, 2..16.
- `WIDTH`, default 8: shared register width.

Ports:
- `clock`  in  1: sole clock; all state updates on its rising edge.
- `reset`  in  1: synchronous, active-high; takes effect only at a rising edge of `clock`.
- `req`  in  `N_REQ`: level request per requester, held until its grant is seen.
- `wdata`  in  `N_REQ*WIDTH`: requester i's data in bits `[i*WIDTH +: WIDTH]`, stable while `req[i]` is high.
- `hold`  in  1: resource stall; suppresses new grants while high.
- `gnt`  out  `N_REQ`: registered one-hot (or zero) grant pulse.
- `gnt_id`  out  `$clog2(N_REQ)`: index of the last granted requester.
- `q`  out  `WIDTH`: shared register contents.
- `busy`  out  1: high in any cycle where `gnt` is nonzero.

## Operation
- **State machine**, one state register:
  - IDLE: no grant this cycle.
  - GRANT: `gnt` nonzero this cycle.
  - STALL: `hold` was sampled high.
- **Eligible set** is `req & ~gnt`. The currently granted requester is masked because its `req` is still high during its grant cycle.
- **Pick:** search upward from pointer `ptr`, wrapping from `N_REQ-1` to 0. The first eligible index wins.
- **At each edge, first match wins:**
  - `reset`: go to IDLE; `gnt` = 0, `q` = 0, `ptr` = 0, `gnt_id` = 0.
  - `hold` high: go to STALL; `gnt` = 0; `q`, `ptr` and `gnt_id` unchanged. Pending requests are not lost.
  - An eligible request exists: go to GRANT; `gnt` = onehot(w), `gnt_id` = w, `q` = `wdata[w]`, `ptr` = (w+1) mod `N_REQ`.
  - Otherwise: go to IDLE; `gnt` = 0.
- **Requester obligation:** drop `req[i]` in the cycle after `gnt[i]` is seen, or keep it high to request another write. A write that stays requested is re-eligible one cycle later, behind any other requester now ahead of it in round-robin order.
- **Fairness:** with all requesters continuously requesting, the grant order is strict rotation, 0,1,2,…,`N_REQ-1`,0.
- **Rules:**
  - `busy` = |`gnt`.
  - At most one `gnt` bit is ever high.
  - `q` changes only in cycles where `gnt` is nonzero, or after a reset.
- **Boundary cases:**
  - A request arriving during STALL is granted the first edge after `hold` falls.
  - Reset asserted while in GRANT: `gnt` and `q` read 0 from the next edge. That write is discarded and the requester must re-request.
  - A single requester holding `req` high is granted every second cycle, because it is masked during its own grant cycle.

## Timing
- **Latency:** `req` sampled high at edge t gives `gnt` and the new `q` valid in cycle t→t+1. That is one edge from request to acknowledge.
- **Throughput:** back-to-back grants to different requesters, one write per cycle.
- **Registered paths:** `gnt`, `gnt_id`, `q` and `busy` are all registered; there is no combinational path from inputs to outputs.
- **`hold`** has a one-edge effect: high at edge t means no grant in cycle t→t+1.
- **Reset values:** `gnt` = 0, `gnt_id` = 0, `q` = 0, `busy` = 0; state IDLE, `ptr` = 0.

## Structure
- **Package `shared_reg_arb_pkg`:**
  - state enum `arb_state_t`: IDLE, GRANT, STALL.
  - default constants `N_REQ_DEF` = 4, `WIDTH_DEF` = 8.
- **Sub-module `rr_pick`:** purely combinational rotating priority encoder.
  - Inputs: eligible vector, `ptr`.
  - Outputs: one-hot winner, winner index, `any`.
  - The top level holds the state, `ptr`, `gnt`, `gnt_id` and the `q` registers, plus the data mux indexed by the winner.

## Test plan
- **Reset:** assert `reset` with `req` = 4'b1111 → after the edge, `gnt` = 0, `q` = 0, `gnt_id` = 0, `busy` = 0.
- **Single requester:** `req` = 4'b0100, `wdata[2]` = 8'hA5 → next cycle `gnt` = 4'b0100, `q` = 8'hA5, `gnt_id` = 2; `ptr` becomes 3.
- **Rotation:** `req` = 4'b1111 held, `wdata[i]` = 8'h10+i → grants 0,1,2,3,0 on consecutive cycles; `q` = 8'h10, 8'h11, 8'h12, 8'h13, 8'h10.
- **Stall:** `req` = 4'b0011 with `hold` high for 3 cycles → `gnt` = 0 and `q` unchanged throughout; the first grant after `hold` drops goes to requester 0, then 1.
- **Reset mid-grant:** reset at the edge following `gnt` = 4'b0010 with `q` = 8'h3C → `gnt` = 0 and `q` = 0 next cycle; the requests still held are then granted starting from index 0.
- **Self-masking:** only `req[1]` held high → `gnt[1]` pulses every other cycle (1,0,1,0); `gnt` is never high two cycles in a row.

Source files
------------

// File: rtl/shared_reg_arbiter_pkg.sv
// rtl/shared_reg_arbiter_pkg.sv - shared types and defaults for the shared register arbiter
package shared_reg_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    STALL = 2'd2
  } arb_state_t;

  localparam int N_REQ_DEF = 4;
  localparam int WIDTH_DEF = 8;

endpackage

// File: rtl/shared_reg_arbiter_rr_pick.sv
// rtl/shared_reg_arbiter_rr_pick.sv - combinational rotating priority encoder
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int IW    = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] elig,
  input  logic [IW-1:0]    ptr,
  output logic [N_REQ-1:0] onehot,
  output logic [IW-1:0]    idx,
  output logic             any_elig
);

  int j;

  // Walk offsets from farthest to nearest so the index closest to ptr is written last.
  always_comb begin
    idx      = '0;
    any_elig = 1'b0;
    j        = 0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      j = int'(ptr) + i;
      if (j >= N_REQ) j = j - N_REQ;
      if (elig[j]) begin
        any_elig = 1'b1;
        idx      = IW'(j);
      end
    end
    onehot = '0;
    if (any_elig) onehot[idx] = 1'b1;
  end

endmodule

// File: rtl/shared_reg_arbiter.sv
// rtl/shared_reg_arbiter.sv - round-robin writer of one shared register among N_REQ requesters
module shared_reg_arbiter
  import shared_reg_arb_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ*WIDTH-1:0]   wdata,
  input  logic                     hold,
  output logic [N_REQ-1:0]         gnt,
  output logic [$clog2(N_REQ)-1:0] gnt_id,
  output logic [WIDTH-1:0]         q,
  output logic                     busy
);

  localparam int IW = $clog2(N_REQ);

  arb_state_t       state, state_nxt;
  logic [IW-1:0]    ptr, ptr_nxt;
  logic [N_REQ-1:0] gnt_nxt;
  logic [IW-1:0]    gnt_id_nxt;
  logic [WIDTH-1:0] q_nxt;
  logic [N_REQ-1:0] elig;
  logic [N_REQ-1:0] win_oh;
  logic [IW-1:0]    win_idx;
  logic             win_any;

  // The requester being acknowledged still has req high this cycle; keep it out.
  assign elig = req & ~gnt;

  rr_pick #(
    .N_REQ (N_REQ),
    .IW    (IW)
  ) u_pick (
    .elig     (elig),
    .ptr      (ptr),
    .onehot   (win_oh),
    .idx      (win_idx),
    .any_elig (win_any)
  );

  always_comb begin
    state_nxt  = IDLE;
    gnt_nxt    = '0;
    gnt_id_nxt = gnt_id;
    q_nxt      = q;
    ptr_nxt    = ptr;
    if (hold) begin
      state_nxt = STALL;
    end else if (win_any) begin
      state_nxt  = GRANT;
      gnt_nxt    = win_oh;
      gnt_id_nxt = win_idx;
      q_nxt      = wdata[win_idx*WIDTH +: WIDTH];
      ptr_nxt    = (win_idx == IW'(N_REQ - 1)) ? '0 : win_idx + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= IDLE;
      ptr    <= '0;
      gnt    <= '0;
      gnt_id <= '0;
      q      <= '0;
    end else begin
      state  <= state_nxt;
      ptr    <= ptr_nxt;
      gnt    <= gnt_nxt;
      gnt_id <= gnt_id_nxt;
      q      <= q_nxt;
    end
  end

  assign busy = (state == GRANT);

endmodule
